// File: rtl/sw_capture_ctrl_pkg.sv
// Package for the switch capture/replay controller.
// Contents:
//   - db_state_t : debounce FSM states.
//   - MODE_CAPTURE / MODE_BROWSE : values of the registered mode switch.
//   - SEG_TABLE / seg_decode : active-low 7-segment patterns (bit0=a .. bit6=g)
//     for hex digits 0-F.
package sw_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK_PRESS,
    HELD,
    CHECK_RELEASE
  } db_state_t;

  localparam logic MODE_CAPTURE = 1'b0;
  localparam logic MODE_BROWSE  = 1'b1;

  // Packed table: element [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] i_val);
    return SEG_TABLE[i_val];
  endfunction

endpackage

// File: rtl/sw_capture_ctrl_if.sv
// Board I/O bundle for sw_capture_ctrl.
// Signals:
//   btn_i   raw enable button (async, active-high)
//   mode_i  0 = capture, 1 = browse
//   data_i  switch word
//   led_o   displayed entry
//   hex0_o  low nibble of displayed entry, active-low segments
//   hex1_o  count (capture) or browse index (browse), active-low segments
//   full_o  history full
//   press_o one-cycle debounced press strobe
// Modports: master drives the inputs (board/bench), slave is the controller.
interface sw_capture_ctrl_if #(
  parameter int DATA_W = 10
);
  logic              btn_i;
  logic              mode_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] led_o;
  logic [6:0]        hex0_o;
  logic [6:0]        hex1_o;
  logic              full_o;
  logic              press_o;

  modport master (
    output btn_i, mode_i, data_i,
    input  led_o, hex0_o, hex1_o, full_o, press_o
  );

  modport slave (
    input  btn_i, mode_i, data_i,
    output led_o, hex0_o, hex1_o, full_o, press_o
  );
endinterface

// File: rtl/sw_capture_ctrl_btn_debounce.sv
// Button synchronizer + debounce FSM.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_btn    raw button, asynchronous to i_clk
//   o_press  registered one-cycle strobe per accepted press
// The button must stay stable for DEBOUNCE_CYCLES cycles both to be accepted
// as pressed and to be accepted as released.
module btn_debounce
  import sw_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  db_state_t       r_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_press;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= CHECK_PRESS;
            r_cnt   <= '0;
          end
        end
        CHECK_PRESS: begin
          if (!r_sync2) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!r_sync2) begin
            r_state <= CHECK_RELEASE;
            r_cnt   <= '0;
          end
        end
        CHECK_RELEASE: begin
          if (r_sync2) begin
            r_state <= HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/sw_capture_ctrl.sv
// Button-sequenced capture/replay controller.
// Ports:
//   clk_50MHZ  system clock
//   rst_n_i    synchronous active-low reset
//   bus        sw_capture_ctrl_if slave: btn_i, mode_i, data_i in;
//              led_o, hex0_o, hex1_o, full_o, press_o out
// Capture mode stores data_i into a circular history on each press; browse
// mode steps backwards from the newest entry on each press.
module sw_capture_ctrl
  import sw_capture_pkg::*;
#(
  parameter int DATA_W          = 10,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk_50MHZ,
  input  logic                rst_n_i,
  sw_capture_ctrl_if.slave    bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic              w_press;
  logic              r_mode;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_idx;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_led;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_mode_rise;
  logic              w_capture;
  logic [PW-1:0]     w_idx_base;
  logic [PW-1:0]     w_idx_step;
  logic [DATA_W-1:0] w_newest;
  logic [DATA_W-1:0] w_browse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (clk_50MHZ),
    .i_rst_n (rst_n_i),
    .i_btn   (bus.btn_i),
    .o_press (w_press)
  );

  // A press lands on the same edge that registers mode_i, so actions are
  // selected by mode_i itself. When that press also enters browse mode, the
  // step starts from index 0 (the entry the mode change would have shown).
  always_comb begin
    w_mode_rise = (r_mode == MODE_CAPTURE) && (bus.mode_i == MODE_BROWSE);
    w_capture   = w_press && (bus.mode_i == MODE_CAPTURE);
    w_idx_base  = w_mode_rise ? '0 : r_idx;
    w_idx_step  = ((CW'(w_idx_base) + CW'(1)) == r_count) ? '0 : w_idx_base + 1'b1;
    w_newest    = r_mem[r_wr_ptr - PW'(1)];
    w_browse    = r_mem[r_wr_ptr - PW'(1) - w_idx_step];
  end

  always_ff @(posedge clk_50MHZ) begin
    if (!rst_n_i) begin
      r_mode   <= MODE_CAPTURE;
      r_wr_ptr <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_led    <= '0;
    end else begin
      r_mode <= bus.mode_i;
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= (r_count == COUNT_FULL) ? r_count : r_count + 1'b1;
        r_led    <= bus.data_i;
        r_idx    <= '0;
      end else if (w_press) begin
        if (r_count != '0) begin
          r_idx <= w_idx_step;
          r_led <= w_browse;
        end else if (w_mode_rise) begin
          r_idx <= '0;
          r_led <= '0;
        end
      end else if (w_mode_rise) begin
        r_idx <= '0;
        r_led <= (r_count == '0) ? '0 : w_newest;
      end
    end
  end

  // History is never read while empty, so it carries no reset.
  always_ff @(posedge clk_50MHZ) begin
    if (rst_n_i && w_capture) begin
      r_mem[r_wr_ptr] <= bus.data_i;
    end
  end

  assign bus.led_o   = r_led;
  assign bus.press_o = w_press;
  assign bus.full_o  = (r_count == COUNT_FULL);
  assign bus.hex0_o  = seg_decode(r_led[3:0]);
  assign bus.hex1_o  = seg_decode((r_mode == MODE_BROWSE) ? 4'(r_idx) : 4'(r_count));

endmodule

// File: tb/tb_sw_capture_ctrl.sv
module tb_sw_capture_ctrl;

  logic clk;
  logic rst_n;

  sw_capture_ctrl_if #(.DATA_W(10)) bus ();

  sw_capture_ctrl #(
    .DATA_W(10),
    .DEPTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_50MHZ (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] led;
    logic [6:0] h0;
    logic [6:0] h1;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_press = 0;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] led, input logic [6:0] h0, input logic [6:0] h1,
                      input logic full);
    exp_t e;
    e.led = led; e.h0 = h0; e.h1 = h1; e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic press();
    bus.btn_i = 1'b1;
    repeat (10) tick();
    bus.btn_i = 1'b0;
    repeat (10) tick();
  endtask

  // Monitor: every strobe must be matched by an expected result, checked on
  // the cycle after the strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.press_o === 1'b1) begin
        n_press++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("unexpected_press", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("press_led",  32'(bus.led_o),  32'(e.led));
          chk("press_hex0", 32'(bus.hex0_o), 32'(e.h0));
          chk("press_hex1", 32'(bus.hex1_o), 32'(e.h1));
          chk("press_full", 32'(bus.full_o), 32'(e.full));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int first;
    rst_n = 1'b0;
    bus.btn_i  = 1'b0;
    bus.mode_i = 1'b0;
    bus.data_i = '0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_led",   32'(bus.led_o),   32'h0);
    chk("rst_full",  32'(bus.full_o),  32'h0);
    chk("rst_press", 32'(bus.press_o), 32'h0);
    chk("rst_hex0",  32'(bus.hex0_o),  32'h40);
    chk("rst_hex1",  32'(bus.hex1_o),  32'h40);

    // Short glitch: no strobe
    p0 = n_press;
    bus.btn_i = 1'b1;
    repeat (3) tick();
    bus.btn_i = 1'b0;
    repeat (12) tick();
    chk("glitch_no_press", 32'(n_press - p0), 32'd0);
    chk("glitch_hex1", 32'(bus.hex1_o), 32'h40);

    // First capture with latency measurement
    bus.data_i = 10'h2A5;
    push(10'h2A5, 7'b0010010, 7'b1111001, 1'b0);
    first = -1;
    bus.btn_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.press_o === 1'b1 && first == -1) first = k;
    end
    bus.btn_i = 1'b0;
    repeat (10) tick();
    chk("press_latency", 32'(first), 32'd6);

    // Clear, then abort a press with reset while in CHECK_PRESS
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    p0 = n_press;
    bus.btn_i = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    bus.btn_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("rst_abort_no_press", 32'(n_press - p0), 32'd0);
    chk("rst_abort_hex1", 32'(bus.hex1_o), 32'h40);

    // Browse with empty history
    bus.mode_i = 1'b1;
    repeat (2) tick();
    chk("empty_browse_led", 32'(bus.led_o), 32'h0);
    p0 = n_press;
    push(10'h0, seg(0), seg(0), 1'b0);
    press();
    chk("empty_browse_pressed", 32'(n_press - p0), 32'd1);
    bus.mode_i = 1'b0;
    repeat (2) tick();

    // Nine captures 1..9
    for (int i = 1; i <= 9; i++) begin
      bus.data_i = 10'(i);
      push(10'(i), seg(i), seg((i > 8) ? 8 : i), (i >= 8));
      press();
    end
    chk("full_after_9", 32'(bus.full_o), 32'd1);
    chk("count8_hex1", 32'(bus.hex1_o), 32'h00);

    // Enter browse: newest entry shown, index 0
    bus.mode_i = 1'b1;
    repeat (2) tick();
    chk("browse_led_newest", 32'(bus.led_o), 32'd9);
    chk("browse_hex1_idx0", 32'(bus.hex1_o), 32'(seg(0)));

    // Step backwards 8..2, then wrap to 9
    for (int k = 1; k <= 7; k++) begin
      push(10'(9 - k), seg(9 - k), seg(k), 1'b1);
      press();
    end
    push(10'd9, seg(9), seg(0), 1'b1);
    press();

    // Back to capture: LED held, count shown
    bus.mode_i = 1'b0;
    repeat (2) tick();
    chk("capture_led_held", 32'(bus.led_o), 32'd9);
    chk("capture_hex1_count", 32'(bus.hex1_o), 32'h00);

    repeat (10) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_capture_ctrl.md
Name: sw_capture_ctrl

Overview:
- Button-sequenced capture/replay controller for the switch-to-LED/7-seg datapath on the lab board.
- Debounces the raw enable button into a single-cycle strobe.
- In capture mode, each strobe stores the switch word into a circular history of DEPTH entries.
- In browse mode, each strobe steps backwards through the stored entries. The selected entry drives led_o and hex0_o; hex1_o shows the entry count (capture mode) or the browse index (browse mode).

Parameters:
DATA_W, 10, width of switch word and LED bus
DEPTH, 8, history entries; power of 2, maximum 15
DEBOUNCE_CYCLES, 4, cycles the synchronized button must stay stable (board build uses 1_000_000)

Ports:
clk_50MHZ  in  1  system clock, 50 MHz
rst_n_i  in  1  synchronous, active-low reset
btn_i  in  1  raw enable button, active-high, asynchronous to clk
mode_i  in  1  0 = capture, 1 = browse; static switch, registered once
data_i  in  DATA_W  switch word to capture
led_o  out  DATA_W  displayed entry, registered
hex0_o  out  7  low nibble of displayed entry; active-low segments, bit0=a .. bit6=g
hex1_o  out  7  count (capture mode) or browse index (browse mode); same encoding as hex0_o
full_o  out  1  count == DEPTH
press_o  out  1  one-cycle debounced press strobe

Behaviour:
- Reset (rst_n_i=0 at a rising edge):
  - sync FFs = 0; FSM = IDLE; debounce counter = 0.
  - count, wr_ptr, idx = 0; mode register = 0.
  - led_o = 0; press_o = 0; full_o = 0; hex0_o = hex1_o = 7'b1000000.
  - History memory is not reset. It is never read while count = 0.
- Synchronizer: 2-FF on btn_i, giving sync.
- Debounce FSM:
  - IDLE: sync=1 -> CHECK_PRESS, cnt=0.
  - CHECK_PRESS:
    - sync=0 -> IDLE.
    - cnt==DEBOUNCE_CYCLES-1 -> HELD and press_o<=1.
    - otherwise cnt++.
  - HELD: sync=0 -> CHECK_RELEASE, cnt=0.
  - CHECK_RELEASE:
    - sync=1 -> HELD.
    - cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - otherwise cnt++.
  - press_o is high for exactly one cycle per accepted press.
- Press latency: with btn_i first sampled high at edge 0, press_o rises after edge 2+DEBOUNCE_CYCLES.
- Action latency: the action is registered at the edge where press_o=1, so led_o, hex and count update one cycle after press_o.
- Capture action (mode=0):
  - mem[wr_ptr] <= data_i; wr_ptr <= wr_ptr+1 mod DEPTH.
  - count <= min(count+1, DEPTH); led_o <= data_i; idx <= 0.
  - When full, the new entry overwrites the oldest and count stays DEPTH.
- Browse action (mode=1):
  - If count=0: no change.
  - Otherwise idx <= (idx+1==count) ? 0 : idx+1.
  - led_o <= mem[(wr_ptr-1-idx') mod DEPTH], where idx' is the new idx.
- Mode change:
  - mode_i is registered each cycle.
  - On a 0->1 change: idx <= 0 and led_o <= newest entry (0 if count=0).
  - On a 1->0 change: led_o is unchanged.
- hex0_o = decode(led_o[3:0]).
- hex1_o = decode(count) in capture mode, decode(idx) in browse mode.
- Both hex outputs are decoded from registered values and are glitch-free after reset.
- Decode table: 0-9 and A-F standard patterns. Example values: 0 = 1000000, 1 = 1111001, 5 = 0010010, 9 = 0010000, 8 = 0000000.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES produces no strobe.
  - Reset in any FSM state aborts the press; no strobe is issued.
  - If the button is still held at reset release, it is re-debounced and produces one strobe.
  - A press coinciding with a mode change uses the newly registered mode.

Decomposition:
- sw_capture_pkg contains:
  - debounce FSM state enum (IDLE, CHECK_PRESS, HELD, CHECK_RELEASE);
  - MODE_CAPTURE / MODE_BROWSE constants;
  - the 16-entry active-low segment table and the decode function.
- One sub-module, btn_debounce: synchronizer, FSM and counter. Parameter DEBOUNCE_CYCLES; outputs press strobe.

Test Plan:
- Reset asserted for 3 cycles -> led_o=0, full_o=0, press_o=0, hex0_o=hex1_o=7'b1000000.
- btn_i high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> press_o never asserts; hex1_o stays 1000000.
- mode_i=0, data_i=10'h2A5, btn_i held 10 cycles -> press_o high for one cycle after edge 6; next cycle led_o=10'h2A5, hex0_o=0010010, hex1_o=1111001.
- Nine captures of values 1..9 -> full_o=1 after the 8th; after the 9th, count=8 (hex1_o=0000000).
  - Switch mode_i=1 -> led_o=9.
  - Seven presses -> led_o = 8, 7, ..., 2.
  - 8th press -> led_o wraps to 9, idx=0.
- rst_n_i pulsed low while FSM is in CHECK_PRESS -> no press_o, count remains 0.
- mode_i=1 with count=0, one clean press -> press_o pulses; led_o stays 0; hex1_o stays 1000000.
